// File: rtl/driver_mon_pkg.sv
// Shared types for the driver-monitor scoring front end: channel count,
// data width, channel tag and weight-bank index names.
package driver_mon_pkg;

   localparam int N_CH = 4;
   localparam int DW   = 8;
   localparam int CH_W = $clog2(N_CH);

   typedef logic [CH_W-1:0] ch_t;
   typedef logic [DW-1:0]   data_t;

   typedef enum logic [1:0] {
      W_ACCEL = 2'd0,
      W_JERK  = 2'd1,
      W_STEER = 2'd2,
      W_BRAKE = 2'd3
   } w_idx_t;

   typedef struct packed {
      logic valid;
      ch_t  ch;
   } tag_t;

endpackage

// File: rtl/score_scheduler_if.sv
// Request/result bus between the sensor front-ends and the scheduler.
interface score_scheduler_if;
   import driver_mon_pkg::*;

   logic [N_CH-1:0]    req_valid;
   logic [N_CH-1:0]    req_ready;
   logic [N_CH*DW-1:0] req_accel;
   logic [N_CH*DW-1:0] req_jerk;
   logic [N_CH*DW-1:0] req_steer;
   logic [N_CH*DW-1:0] req_brake;
   logic               res_valid;
   ch_t                res_ch;
   data_t              res_score;

   modport master (
      output req_valid, req_accel, req_jerk, req_steer, req_brake,
      input  req_ready, res_valid, res_ch, res_score
   );

   modport slave (
      input  req_valid, req_accel, req_jerk, req_steer, req_brake,
      output req_ready, res_valid, res_ch, res_score
   );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from the pointer,
// pointer moves just past the winner on each grant.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          grant_valid
);

   logic [IW-1:0] ptr_q;
   logic [IW-1:0] idx;

   // N is a power of two, so the pointer offset wraps for free.
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      idx         = '0;
      for (int i = 0; i < N; i++) begin
         idx = ptr_q + IW'(i);
         if (!grant_valid && req[idx]) begin
            grant_valid = 1'b1;
            grant_idx   = idx;
            grant[idx]  = 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (grant_valid) begin
         ptr_q <= grant_idx + IW'(1);
      end
   end

endmodule

// File: rtl/score_scheduler.sv
// Shares one 3-stage scoring pipeline between N_CH channels: arbitration,
// weight banks, tag tracking, tagged result capture and sticky high-score alerts.
module score_scheduler
   import driver_mon_pkg::*;
#(
   parameter data_t ALERT_TH  = 8'd200,
   parameter int    ALERT_CNT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   score_scheduler_if.slave bus,
   input  logic             cfg_we,
   input  ch_t              cfg_ch,
   input  logic [1:0]       cfg_idx,
   input  data_t            cfg_wdata,
   output data_t            p_accel,
   output data_t            p_jerk,
   output data_t            p_steer,
   output data_t            p_brake,
   output data_t            p_w0,
   output data_t            p_w1,
   output data_t            p_w2,
   output data_t            p_w3,
   input  data_t            p_score,
   output logic [N_CH-1:0]  alert,
   input  logic [N_CH-1:0]  alert_clr,
   output logic             busy
);

   localparam logic [3:0] CNT_MAX = 4'(ALERT_CNT);

   logic [N_CH-1:0] cand;
   logic [N_CH-1:0] grant;
   ch_t             gidx;
   logic            gvalid;
   data_t           wbank [N_CH][4];
   tag_t            tag_q [4];
   logic [3:0]      cnt_q [N_CH];

   assign cand          = en ? bus.req_valid : '0;
   assign bus.req_ready = grant;

   rr_arbiter #(.N(N_CH), .IW(CH_W)) u_arb (
      .clk         (clk),
      .rst         (rst),
      .req         (cand),
      .grant       (grant),
      .grant_idx   (gidx),
      .grant_valid (gvalid)
   );

   // NOTE: the weight bank is a small flop array, so it is reset like any other register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < N_CH; c++)
            for (int w = 0; w < 4; w++)
               wbank[c][w] <= '0;
      end else if (cfg_we) begin
         wbank[cfg_ch][cfg_idx] <= cfg_wdata;
      end
   end

   // A same-edge weight write is not visible here until the next grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_accel <= '0;
         p_jerk  <= '0;
         p_steer <= '0;
         p_brake <= '0;
         p_w0    <= '0;
         p_w1    <= '0;
         p_w2    <= '0;
         p_w3    <= '0;
      end else if (gvalid) begin
         p_accel <= bus.req_accel[gidx*DW +: DW];
         p_jerk  <= bus.req_jerk[gidx*DW +: DW];
         p_steer <= bus.req_steer[gidx*DW +: DW];
         p_brake <= bus.req_brake[gidx*DW +: DW];
         p_w0    <= wbank[gidx][W_ACCEL];
         p_w1    <= wbank[gidx][W_JERK];
         p_w2    <= wbank[gidx][W_STEER];
         p_w3    <= wbank[gidx][W_BRAKE];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++)
            tag_q[i] <= '0;
      end else begin
         tag_q[0] <= '{valid: gvalid, ch: gidx};
         for (int i = 1; i < 4; i++)
            tag_q[i] <= tag_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.res_valid <= 1'b0;
         bus.res_ch    <= '0;
         bus.res_score <= '0;
      end else begin
         bus.res_valid <= tag_q[3].valid;
         if (tag_q[3].valid) begin
            bus.res_ch    <= tag_q[3].ch;
            bus.res_score <= p_score;
         end
      end
   end

   // Clear has priority over a qualifying capture on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < N_CH; c++) begin
            cnt_q[c] <= '0;
            alert[c] <= 1'b0;
         end
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            if (alert_clr[c]) begin
               cnt_q[c] <= '0;
               alert[c] <= 1'b0;
            end else if (tag_q[3].valid && tag_q[3].ch == CH_W'(c)) begin
               if (p_score >= ALERT_TH) begin
                  if (cnt_q[c] != CNT_MAX) begin
                     cnt_q[c] <= cnt_q[c] + 4'd1;
                     if (cnt_q[c] + 4'd1 == CNT_MAX)
                        alert[c] <= 1'b1;
                  end
               end else begin
                  cnt_q[c] <= '0;
               end
            end
         end
      end
   end

   assign busy = tag_q[0].valid | tag_q[1].valid | tag_q[2].valid | tag_q[3].valid;

endmodule

// File: tb/tb_score_scheduler.sv
// Self-checking bench: behavioural 3-stage scoring pipeline, RR grant model and
// a result scoreboard filled at grant time and drained when res_valid appears.
module tb_score_scheduler;
   import driver_mon_pkg::*;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             cfg_we;
   ch_t              cfg_ch;
   logic [1:0]       cfg_idx;
   data_t            cfg_wdata;
   data_t            p_accel, p_jerk, p_steer, p_brake;
   data_t            p_w0, p_w1, p_w2, p_w3;
   data_t            p_score;
   logic [N_CH-1:0]  alert;
   logic [N_CH-1:0]  alert_clr;
   logic             busy;

   score_scheduler_if ifc ();

   score_scheduler #(.ALERT_TH(8'd200), .ALERT_CNT(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .bus       (ifc),
      .cfg_we    (cfg_we),
      .cfg_ch    (cfg_ch),
      .cfg_idx   (cfg_idx),
      .cfg_wdata (cfg_wdata),
      .p_accel   (p_accel),
      .p_jerk    (p_jerk),
      .p_steer   (p_steer),
      .p_brake   (p_brake),
      .p_w0      (p_w0),
      .p_w1      (p_w1),
      .p_w2      (p_w2),
      .p_w3      (p_w3),
      .p_score   (p_score),
      .alert     (alert),
      .alert_clr (alert_clr),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;
   int cyc   = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] clamp8(input int v);
      if (v < 0) return 8'd0;
      if (v > 255) return 8'd255;
      return 8'(v);
   endfunction

   // Behavioural ml_pipeline: products, sum, clamped score; reset as ~rst.
   int   m0, m1, m2, m3, psum;
   logic [7:0] score_q;
   assign p_score = score_q;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m0 <= 0; m1 <= 0; m2 <= 0; m3 <= 0; psum <= 0; score_q <= '0;
      end else begin
         m0      <= int'($signed(p_accel)) * int'($signed(p_w0));
         m1      <= int'($signed(p_jerk))  * int'($signed(p_w1));
         m2      <= int'($signed(p_steer)) * int'($signed(p_w2));
         m3      <= int'(p_brake)          * int'($signed(p_w3));
         psum    <= m0 + m1 + m2 + m3;
         score_q <= clamp8(psum);
      end
   end

   typedef struct {
      int ch;
      int score;
      int gcyc;
   } exp_t;

   exp_t sb [$];
   exp_t mon_e;
   int   tb_ptr = 0;
   int   tb_w [N_CH][4];
   int   s_acc [N_CH], s_jrk [N_CH], s_str [N_CH], s_brk [N_CH];

   function automatic int exp_score(input int c);
      int s;
      s = s_acc[c]*tb_w[c][0] + s_jrk[c]*tb_w[c][1] + s_str[c]*tb_w[c][2] + s_brk[c]*tb_w[c][3];
      return int'(clamp8(s));
   endfunction

   task automatic set_sample(input int c, input int a, input int j, input int s, input int b);
      s_acc[c] = a; s_jrk[c] = j; s_str[c] = s; s_brk[c] = b;
      ifc.req_accel[c*DW +: DW] = 8'(a);
      ifc.req_jerk[c*DW +: DW]  = 8'(j);
      ifc.req_steer[c*DW +: DW] = 8'(s);
      ifc.req_brake[c*DW +: DW] = 8'(b);
   endtask

   // One clock: check the grant against the RR model, score it, apply config.
   task automatic step();
      logic [N_CH-1:0] cnd;
      logic [N_CH-1:0] exp_rdy;
      int g;
      #1;
      cnd = en ? ifc.req_valid : '0;
      g = -1;
      for (int i = 0; i < N_CH; i++) begin
         int k;
         k = (tb_ptr + i) % N_CH;
         if (g < 0 && cnd[k]) g = k;
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", ifc.req_ready, exp_rdy);
      if (g >= 0) begin
         sb.push_back('{ch: g, score: exp_score(g), gcyc: cyc + 1});
         tb_ptr = (g + 1) % N_CH;
      end
      if (cfg_we) tb_w[cfg_ch][cfg_idx] = int'($signed(cfg_wdata));
      @(negedge clk);
      cfg_we    = 1'b0;
      alert_clr = '0;
   endtask

   task automatic wr_w(input int c, input int idx, input int val);
      cfg_we    = 1'b1;
      cfg_ch    = ch_t'(c);
      cfg_idx   = 2'(idx);
      cfg_wdata = 8'(val);
      step();
   endtask

   task automatic bench_reset_model();
      sb.delete();
      tb_ptr = 0;
      for (int c = 0; c < N_CH; c++)
         for (int w = 0; w < 4; w++)
            tb_w[c][w] = 0;
   endtask

   // Issue one ch1 sample, drain it, optionally clear on the capture edge.
   task automatic alert_shot(input int acc, input logic clr, input logic [N_CH-1:0] exp_alert, input string tag);
      set_sample(1, acc, 0, 0, 0);
      ifc.req_valid = 4'b0010;
      step();
      ifc.req_valid = '0;
      repeat (3) step();
      if (clr) alert_clr = 4'b0010;
      step();
      check(tag, alert, exp_alert);
   endtask

   always @(negedge clk) begin
      if (!rst && ifc.res_valid) begin
         if (sb.size() == 0) begin
            check("res_extra", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            check("res_ch", ifc.res_ch, mon_e.ch);
            check("res_score", ifc.res_score, mon_e.score);
            check("res_latency", cyc - mon_e.gcyc, 4);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; en = 1'b1;
      cfg_we = 1'b0; cfg_ch = '0; cfg_idx = '0; cfg_wdata = '0; alert_clr = '0;
      ifc.req_valid = '0;
      ifc.req_accel = '0; ifc.req_jerk = '0; ifc.req_steer = '0; ifc.req_brake = '0;
      bench_reset_model();
      for (int c = 0; c < N_CH; c++) set_sample(c, 0, 0, 0, 0);

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_res", {ifc.res_valid, ifc.res_ch, ifc.res_score}, '0);
      check("rst_p", {p_accel, p_jerk, p_steer, p_brake, p_w0, p_w1, p_w2, p_w3}, '0);
      check("rst_alert", alert, '0);
      check("rst_busy", busy, 0);
      check("rst_ready", ifc.req_ready, '0);
      rst = 1'b0;
      repeat (10) step();
      check("idle_p", {p_accel, p_jerk, p_steer, p_brake, p_w0, p_w1, p_w2, p_w3}, '0);
      check("idle_busy", busy, 0);

      // Round-robin with distinct per-channel weights and samples
      for (int c = 0; c < N_CH; c++) begin
         wr_w(c, 0, c + 1);
         wr_w(c, 1, 1);
         wr_w(c, 2, 2);
         wr_w(c, 3, c);
         set_sample(c, 10*c + 3, 5 - c, 3*c - 7, 40 + 20*c);
      end
      ifc.req_valid = '1;
      repeat (8) step();
      ifc.req_valid = '0;
      repeat (6) step();
      check("rr_drained", sb.size(), 0);
      check("rr_busy", busy, 0);

      // Single path: ch0 w0=2, accel=10 -> 20 after exactly 4 cycles
      wr_w(0, 0, 2); wr_w(0, 1, 0); wr_w(0, 2, 0); wr_w(0, 3, 0);
      set_sample(0, 10, 7, -3, 90);
      ifc.req_valid = 4'b0001;
      step();
      ifc.req_valid = '0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("single_early", ifc.res_valid, 0);
      end
      step();
      check("single_valid", ifc.res_valid, 1);
      check("single_score", ifc.res_score, 20);
      step();
      check("single_pulse", ifc.res_valid, 0);

      // Clamp high/low and same-edge weight write hazard on ch2
      wr_w(2, 0, 127); wr_w(2, 1, 0); wr_w(2, 2, 0); wr_w(2, 3, 0);
      set_sample(2, 127, 0, 0, 0);
      ifc.req_valid = 4'b0100;
      step();
      ifc.req_valid = '0;
      wr_w(2, 0, -1);
      set_sample(2, 5, 0, 0, 0);
      ifc.req_valid = 4'b0100;
      step();
      set_sample(2, 10, 0, 0, 0);
      cfg_we = 1'b1; cfg_ch = 2'd2; cfg_idx = 2'd0; cfg_wdata = 8'd3;
      step();
      step();
      ifc.req_valid = '0;
      repeat (6) step();
      check("clamp_drained", sb.size(), 0);

      // Alert on ch1: 210,210,150,210,210,210 then clear-wins, then re-arm
      wr_w(1, 0, 2); wr_w(1, 1, 0); wr_w(1, 2, 0); wr_w(1, 3, 0);
      alert_clr = '1;
      step();
      check("alert_cleared", alert, '0);
      alert_shot(105, 1'b0, 4'b0000, "alert_1");
      alert_shot(105, 1'b0, 4'b0000, "alert_2");
      alert_shot(75,  1'b0, 4'b0000, "alert_3");
      alert_shot(105, 1'b0, 4'b0000, "alert_4");
      alert_shot(105, 1'b0, 4'b0000, "alert_5");
      alert_shot(105, 1'b0, 4'b0010, "alert_6");
      alert_shot(105, 1'b1, 4'b0000, "alert_clr_wins");
      alert_shot(105, 1'b0, 4'b0000, "alert_rearm_1");
      alert_shot(105, 1'b0, 4'b0000, "alert_rearm_2");
      alert_shot(105, 1'b0, 4'b0010, "alert_rearm_3");

      // Reset mid-flight: three grants, reset two cycles later
      for (int c = 0; c < N_CH; c++) set_sample(c, 20 + c, 1, 1, 1);
      ifc.req_valid = 4'b0111;
      repeat (3) step();
      ifc.req_valid = '0;
      repeat (2) step();
      #2;
      rst = 1'b1;
      bench_reset_model();
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_res", ifc.res_valid, 0);
      check("midrst_alert", alert, '0);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) step();
      check("midrst_quiet", ifc.res_valid, 0);
      check("midrst_idle", busy, 0);

      // en low with pending requests: no grants, in-flight results drain
      for (int c = 0; c < N_CH; c++) begin
         wr_w(c, 0, 1);
         wr_w(c, 3, 1);
         set_sample(c, 30*c - 20, 9, -9, 60);
      end
      ifc.req_valid = '1;
      repeat (3) step();
      en = 1'b0;
      step();
      check("en_busy", busy, 1);
      repeat (6) step();
      check("en_drained", sb.size(), 0);
      check("en_idle", busy, 0);
      ifc.req_valid = '0;
      en = 1'b1;
      repeat (2) step();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/score_scheduler.md
# score_scheduler

Front-end controller for the driver-monitor scoring pipeline (`ml_pipeline`). It shares one pipeline instance between `N_CH` sensor channels: round-robin arbitration, per-channel weight banks, issue and tag tracking through the 3-stage pipeline, and tagged result delivery. It also keeps a per-channel sticky alert for sustained high scores, and sits between the sensor front-ends and the alert/reporting logic.

## Interface
- `N_CH`, 4: number of requesting channels (power of two, ≥2).
- `ALERT_TH`, 8'd200: a score ≥ this counts as "high".
- `ALERT_CNT`, 3: consecutive high results per channel needed to raise its alert (1–15).

Ports (direction, width, meaning):
- `clk`, in, 1: single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `en`, in, 1: when low, no new grants; in-flight results still drain.
- `req_valid`, in, `N_CH`: per-channel sample valid.
- `req_ready`, out, `N_CH`: one-hot grant; combinational from `req_valid`, `en` and the RR pointer.
- `req_accel`, `req_jerk`, `req_steer`, in, `N_CH*8`: signed samples packed by channel, ch0 in LSBs.
- `req_brake`, in, `N_CH*8`: unsigned, packed likewise.
- `cfg_we`, in, 1: weight write strobe.
- `cfg_ch`, in, log2(`N_CH`): channel to write.
- `cfg_idx`, in, 2: weight index (0 accel, 1 jerk, 2 steer, 3 brake).
- `cfg_wdata`, in, 8: signed weight.
- `p_accel`, `p_jerk`, `p_steer`, `p_brake`, `p_w0`..`p_w3`, out, 8 each: registered drive to the pipeline inputs.
- `p_score`, in, 8: pipeline `score` output.
- `res_valid`, out, 1: result strobe (one cycle).
- `res_ch`, out, log2(`N_CH`): channel tag for the result.
- `res_score`, out, 8: captured score.
- `alert`, out, `N_CH`: sticky per-channel alert.
- `alert_clr`, in, `N_CH`: per-channel alert/counter clear.
- `busy`, out, 1: any issue or tag stage valid.

## Operation
- **Arbitration**
  - Candidate set = `req_valid` when `en`, else empty.
  - The first set bit at or after `rr_ptr` (wrapping) wins, and its `req_ready` bit is asserted.
  - A transfer occurs when `req_valid & req_ready`; at most one per cycle.
  - On a grant to channel k, `rr_ptr` ← (k+1) mod `N_CH`. With no grant, the pointer holds.
- **Issue**
  - On a grant edge, the winner's four samples and its four bank weights are registered onto `p_*`.
  - Tag stage 0 is loaded with {valid, ch}. With no grant, stage 0 valid ← 0 and `p_*` hold.
- **Weight bank**
  - `N_CH`×4 signed 8-bit registers, written at the `cfg_we` edge.
  - A write and a grant of the same channel on the same edge: the issue uses the old weight; the new weight applies to later grants.
- **Tag pipe**
  - Stages 0..3 shift every cycle, mirroring `ml_pipeline`: m at +1, sum at +2, score at +3.
  - When stage 3 is valid, `p_score` belongs to that tag. On the next edge: `res_valid` ← 1, `res_ch` ← tag, `res_score` ← `p_score`.
- **Alert**
  - Per-channel 4-bit counter, updated at result capture of that channel only.
  - Score ≥ `ALERT_TH`: the counter increments (saturating at `ALERT_CNT`). Otherwise it goes to 0.
  - `alert[ch]` sets on the same edge the counter reaches `ALERT_CNT` and stays set until `alert_clr[ch]`.
  - `alert_clr[ch]` zeros both the alert and the counter. If a clear and a qualifying capture fall on the same edge, the clear wins.
- **Reset**
  - All registers go to 0: `p_*`, weights, tags, `res_*`, `alert`, counters, `rr_ptr`.
  - In-flight samples are discarded and produce no `res_valid` after reset.
  - The pipeline's active-low reset is driven as `~rst` at the top level, so both clear together.

## Timing
- Grant edge E → `res_valid` high in the cycle after edge E+4. Accept-to-result latency is fixed at 4 cycles.
- Throughput is one result per cycle. Results appear in grant order.
- `en` falling: no grant that cycle; up to 4 results still emerge. `busy` falls one cycle after the last tag leaves stage 3.
- `res_valid` is one cycle wide unless back-to-back results follow. There is no backpressure on results.

## Structure
- Package `driver_mon_pkg`:
  - `N_CH` and the data width (8).
  - Channel-index type.
  - Weight-index enum `W_ACCEL`, `W_JERK`, `W_STEER`, `W_BRAKE`.
- Sub-module `rr_arbiter`: parameterized `N_CH` round-robin grant with pointer, combinational grant and registered pointer. All else stays in `score_scheduler`.

## Test plan
- **Reset:** hold `rst`. All outputs are 0 and `req_ready` = 0. Release with `req_valid` = 0 → nothing changes for 10 cycles.
- **Single path:** write ch0 w0 = 2 (others 0), ch0 accel = 10 valid for 1 cycle → `res_valid` exactly 4 cycles after accept, `res_ch` = 0, `res_score` = 20.
- **Round-robin:** all 4 valid continuously for 8 cycles → grants 0,1,2,3,0,1,2,3. Results carry the same channel order, 1 per cycle.
- **Clamp and config hazard:**
  - ch2 w0 = 127, accel = 127 → 255.
  - w0 = −1, accel = 5 → 0.
  - Write ch2 w0 = 3 on the same edge as a ch2 grant → that result uses the old weight; the next uses 3.
- **Alert:** ch1 results 210, 210, 150, 210, 210, 210 → `alert[1]` rises on the 6th capture only. `alert_clr[1]` on the same edge as a further 210 → alert and counter are 0.
- **Reset mid-flight:**
  - Grant 3 samples, assert `rst` 2 cycles later for 1 cycle → no `res_valid` afterwards, `busy` = 0.
  - `en` low with requests pending → no grants, and in-flight results still complete.
